// File: rtl/seven_seg_banner_mux_if.sv
// Banner request and display-pin bundle for seven_seg_banner_mux.
// The master drives the message and controls; the slave drives the pins.
interface seven_seg_banner_mux_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8
);
  logic                   show;
  logic [5*MSG_LEN-1:0]   msg;
  logic                   hold;
  logic                   clear;
  logic [NUM_DIGITS-1:0]  blink_mask;
  logic [6:0]             seg;
  logic [NUM_DIGITS-1:0]  an;
  logic                   busy;

  modport master (
    output show, msg, hold, clear, blink_mask,
    input  seg, an, busy
  );

  modport slave (
    input  show, msg, hold, clear, blink_mask,
    output seg, an, busy
  );
endinterface

// File: rtl/seven_seg_banner_mux.sv
// Multiplexed 7-segment banner driver: latched message, timed or held,
// scrolling when longer than the display, with per-digit blinking.
module seven_seg_banner_mux #(
  parameter int NUM_DIGITS    = 4,
  parameter int MSG_LEN       = 8,
  parameter int MUX_CYCLES    = 50000,
  parameter int SCROLL_CYCLES = 25000000,
  parameter int SHOW_CYCLES   = 50000000,
  parameter int BLINK_CYCLES  = 12500000
) (
  input logic clk,
  input logic rst,
  seven_seg_banner_mux_if.slave bus
);

  localparam int OMAX = MSG_LEN - NUM_DIGITS;
  localparam int MW   = (MUX_CYCLES > 1) ? $clog2(MUX_CYCLES) : 1;
  localparam int CW   = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam int LW   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int BW   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int OW   = (OMAX > 0) ? $clog2(OMAX + 1) : 1;
  localparam int SW   = $clog2(NUM_DIGITS + 1);
  localparam int IW   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [4:0]            chars_q [MSG_LEN];
  logic [MW-1:0]         mux_q;
  logic [SW-1:0]         slot_q;
  logic [CW-1:0]         scnt_q;
  logic [OW-1:0]         offset_q;
  logic [LW-1:0]         life_q;
  logic [BW-1:0]         bcnt_q;
  logic                  phase_q;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [IW-1:0]         idx;
  logic                  busy_q;
  logic                  start;
  logic                  timeout;

  function automatic logic [6:0] char_seg(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'h00:   s = 7'b0111111;
      5'h01:   s = 7'b0000110;
      5'h02:   s = 7'b1011011;
      5'h03:   s = 7'b1001111;
      5'h04:   s = 7'b1100110;
      5'h05:   s = 7'b1101101;
      5'h06:   s = 7'b1111101;
      5'h07:   s = 7'b0000111;
      5'h08:   s = 7'b1111111;
      5'h09:   s = 7'b1101111;
      5'h0A:   s = 7'b1110111;
      5'h0B:   s = 7'b1111100;
      5'h0C:   s = 7'b0111001;
      5'h0D:   s = 7'b1011110;
      5'h0E:   s = 7'b1111001;
      5'h0F:   s = 7'b1110001;
      5'h11:   s = 7'b1110110;
      5'h12:   s = 7'b0111000;
      5'h13:   s = 7'b0110111;
      5'h14:   s = 7'b0000111;
      5'h15:   s = 7'b1000000;
      5'h16:   s = 7'b1110011;
      5'h17:   s = 7'b1010000;
      5'h18:   s = 7'b0111110;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign busy_q  = (state_q == ACTIVE);
  assign start   = bus.show & ~bus.clear;
  assign timeout = ~bus.hold & (life_q == LW'(SHOW_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (bus.clear)   state_d = IDLE;
        else if (start)  state_d = ACTIVE;
        else if (timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_q  <= '0;
      slot_q <= '0;
    end else if (mux_q == MW'(MUX_CYCLES - 1)) begin
      mux_q  <= '0;
      slot_q <= (slot_q == SW'(NUM_DIGITS)) ? '0 : slot_q + 1'b1;
    end else begin
      mux_q  <= mux_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) chars_q[i] <= '0;
      life_q   <= '0;
      scnt_q   <= '0;
      offset_q <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < MSG_LEN; i++) chars_q[i] <= bus.msg[5*i +: 5];
      life_q   <= '0;
      scnt_q   <= '0;
      offset_q <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
    end else if (busy_q) begin
      // life freezes at its terminal value; the FSM drops busy there
      if (!bus.hold && life_q != LW'(SHOW_CYCLES - 1))
        life_q <= life_q + 1'b1;
      if (OMAX > 0) begin
        if (scnt_q == CW'(SCROLL_CYCLES - 1)) begin
          scnt_q   <= '0;
          offset_q <= (offset_q == OW'(OMAX)) ? '0 : offset_q + 1'b1;
        end else begin
          scnt_q <= scnt_q + 1'b1;
        end
      end
      if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  assign idx = IW'(offset_q) + IW'(slot_q);

  // the blanking slot matches no digit, so it falls through to all-off
  always_comb begin
    seg_d = '0;
    an_d  = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (busy_q && slot_q == SW'(d) &&
          !(phase_q && bus.blink_mask[d])) begin
        an_d[d] = 1'b1;
        seg_d   = char_seg(chars_q[idx]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= '0;
      an_q  <= '0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_seven_seg_banner_mux.sv
// Scoreboard bench for seven_seg_banner_mux: an arithmetic reference
// model predicts seg/an/busy each cycle; a negedge monitor compares.
module tb_seven_seg_banner_mux;
  localparam int ND    = 4;
  localparam int ML    = 6;
  localparam int MUXC  = 4;
  localparam int SCR   = 40;
  localparam int SHOWC = 200;
  localparam int BLK   = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_banner_mux_if #(.NUM_DIGITS(ND), .MSG_LEN(ML)) bus ();

  seven_seg_banner_mux #(
    .NUM_DIGITS(ND), .MSG_LEN(ML), .MUX_CYCLES(MUXC),
    .SCROLL_CYCLES(SCR), .SHOW_CYCLES(SHOWC), .BLINK_CYCLES(BLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          busy;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int checks = 0;
  int passed = 0;

  logic [6:0] ref_tab [0:24];

  bit m_busy;
  int m_k;
  int m_unheld;
  int m_n;
  int m_chars [ML];

  function automatic logic [6:0] ref_seg(int c);
    return (c < 25) ? ref_tab[c] : 7'b0;
  endfunction

  function automatic logic [5*ML-1:0] mk6(int a, int b, int c,
                                           int d, int e, int f);
    logic [5*ML-1:0] m;
    m = {5'(f), 5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    return m;
  endfunction

  // One clock: predict outputs from state before the edge, then advance.
  task automatic step();
    exp_t e;
    int slot, off, ph;
    slot = (m_n / MUXC) % (ND + 1);
    off  = (m_k / SCR) % (ML - ND + 1);
    ph   = (m_k / BLK) % 2;
    e = '0;
    if (!rst && m_busy && slot < ND &&
        !(ph == 1 && bus.blink_mask[slot])) begin
      e.an  = ND'(1) << slot;
      e.seg = ref_seg(m_chars[off + slot]);
    end
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_n = 0; m_k = 0; m_unheld = 0;
    end else begin
      m_n++;
      if (bus.show && !bus.clear) begin
        m_busy = 1; m_k = 0; m_unheld = 0;
        for (int i = 0; i < ML; i++) m_chars[i] = int'(bus.msg[5*i +: 5]);
      end else if (bus.clear) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_k++;
        if (!bus.hold) begin
          m_unheld++;
          if (m_unheld == SHOWC) m_busy = 0;
        end
      end
    end
    e.busy = m_busy;
    sb.push_back(e);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_show(logic [5*ML-1:0] m);
    bus.msg  = m;
    bus.show = 1'b1;
    step();
    bus.show = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      checks++;
      if (bus.seg === me.seg && bus.an === me.an && bus.busy === me.busy)
        passed++;
      else
        $display("FAIL out t=%0t got seg=%b an=%b busy=%b want seg=%b an=%b busy=%b",
                 $time, bus.seg, bus.an, bus.busy, me.seg, me.an, me.busy);
    end
  end

  initial begin
    ref_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001,
                7'b0000000, 7'b1110110, 7'b0111000, 7'b0110111,
                7'b0000111, 7'b1000000, 7'b1110011, 7'b1010000,
                7'b0111110};
    m_busy = 0; m_k = 0; m_unheld = 0; m_n = 0;
    for (int i = 0; i < ML; i++) m_chars[i] = 0;
    rst = 1'b1;
    bus.show = 1'b0;
    bus.clear = 1'b0;
    bus.hold = 1'b0;
    bus.blink_mask = '0;
    bus.msg = '0;
    run(3);
    rst = 1'b0;
    run(5);

    // static banner, then natural timeout
    do_show(mk6(5, 'h14, 0, 'h10, 'h10, 'h10));
    run(215);

    // scrolling through two wraps
    do_show(mk6(1, 2, 3, 4, 5, 6));
    run(170);
    do_clear();
    run(6);

    // hold freezes the lifetime
    bus.hold = 1'b1;
    do_show(mk6(7, 8, 9, 'hA, 'hB, 'hC));
    run(499);
    bus.hold = 1'b0;
    run(210);

    // blink digit 1
    bus.blink_mask = 4'b0010;
    do_show(mk6('h11, 'h12, 'h13, 'h16, 'h17, 'h18));
    run(60);
    do_clear();
    bus.blink_mask = '0;
    run(4);

    // clear beats simultaneous show
    do_show(mk6(1, 2, 3, 4, 5, 6));
    run(20);
    bus.msg = mk6(9, 9, 9, 9, 9, 9);
    bus.show = 1'b1;
    bus.clear = 1'b1;
    step();
    bus.show = 1'b0;
    bus.clear = 1'b0;
    run(10);

    // asynchronous reset mid-scroll
    do_show(mk6(1, 2, 3, 4, 5, 6));
    run(60);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.seg === 7'b0 && bus.an === '0 && bus.busy === 1'b0)
      passed++;
    else
      $display("FAIL async_rst got seg=%b an=%b busy=%b want all zero",
               bus.seg, bus.an, bus.busy);
    m_busy = 0; m_n = 0; m_k = 0; m_unheld = 0;
    run(2);
    rst = 1'b0;
    do_show(mk6('hD, 'hE, 'hF, 'h15, 0, 1));
    run(60);

    // randomized banners
    for (int it = 0; it < 30; it++) begin
      bus.hold = 1'b0;
      bus.blink_mask = ND'($urandom);
      do_show(mk6($urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31)));
      for (int j = 0; j < int'($urandom_range(50, 260)); j++) begin
        if ($urandom_range(0, 19) == 0) bus.hold = ~bus.hold;
        if ($urandom_range(0, 249) == 0) begin
          do_clear();
        end else if ($urandom_range(0, 299) == 0) begin
          do_show(mk6($urandom_range(0, 31), 1, 2, 3, 4,
                      $urandom_range(0, 31)));
        end else begin
          step();
        end
      end
    end
    bus.hold = 1'b0;
    run(3);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
